// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

    // Loader controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CKSUM = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int IMEM_ADDR_W    = 8;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream into little-endian 32-bit words (first byte -> bits [7:0]).
// Latency: word_vld is combinational on the 4th byte; word_dat holds the full word the cycle after.
// Backpressure: none; it consumes whatever byte_vld presents, the caller gates acceptance.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr         restart at lane 0 (new load)
//   byte_vld    byte accepted this cycle
//   byte_dat    accepted byte
//   word_vld    this byte completes a word
//   word_dat    shift register; valid as a full word after word_vld
module imem_word_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       shift_q, shift_d;

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clr) begin
            lane_d = '0;
        end else if (byte_vld) begin
            // Lane counter wraps naturally after the last byte of a word.
            lane_d  = lane_q + LANE_W'(1);
            // Shift right so the first byte ends up in the least significant lane.
            shift_d = {byte_dat, shift_q[31:8]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

    assign word_vld = byte_vld && (lane_q == LAST_LANE);
    assign word_dat = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (2-byte LE word count, then 4*N LE data bytes) into imem from address 0.
// Latency: mem_we pulses for one cycle, the cycle after the 4th byte of a word is accepted.
// Backpressure: in_ready drops during the write cycle and while idle/done; byte lane is held when in_valid is low.
//
// Optional feature: define IMEM_LOADER_CKSUM_EN to expect one trailing XOR checksum byte
// after the data (header excluded); a mismatch sets cksum_err. Otherwise cksum_err is 0.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                begin a load (only honoured in IDLE or DONE)
//   in_valid/in_data     byte stream input, in_ready acceptance handshake
//   mem_we/addr/wdata    imem write port
//   busy, done           load in progress / load complete (held until next start)
//   overflow             header count larger than the memory depth (sticky until start)
//   word_cnt             words processed in this load
//   cksum_err            checksum mismatch
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              cksum_err
);

    // Memory depth, one bit wider than the count so 2**16 is representable.
    localparam logic [CNT_W:0] DEPTH   = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;
    localparam logic [CNT_W:0] ONE_EXT = {{CNT_W{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t AFTER_DATA = CKSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             overflow_q, overflow_d;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]       xor_q, xor_d;
    logic             cksum_err_q, cksum_err_d;
`endif

    logic             accept;
    logic             clr_lane;
    logic             word_vld;
    logic [31:0]      word_dat;
    logic [CNT_W-1:0] hdr_cnt;
    logic [CNT_W:0]   next_cnt;
    logic             in_range;

    assign in_ready = (state_q == HDR0) || (state_q == HDR1) ||
                      (state_q == DATA) || (state_q == CKSUM);
    assign accept   = in_valid && in_ready;
    assign hdr_cnt  = CNT_W'({in_data, count_q[7:0]});
    assign next_cnt = {1'b0, word_cnt_q} + ONE_EXT;
    // Words past the end of memory are consumed but never written (no wrap).
    assign in_range = ({1'b0, word_cnt_q} < DEPTH);

    imem_word_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_lane),
        .byte_vld (accept && (state_q == DATA)),
        .byte_dat (in_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        overflow_d = overflow_q;
        clr_lane   = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
        xor_d       = xor_q;
        cksum_err_d = cksum_err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = HDR0;
                    word_cnt_d = '0;
                    overflow_d = 1'b0;
                    clr_lane   = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
                    xor_d       = '0;
                    cksum_err_d = 1'b0;
`endif
                end
            end
            HDR0: begin
                if (accept) begin
                    count_d = CNT_W'(in_data);
                    state_d = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    count_d = hdr_cnt;
                    if ({1'b0, hdr_cnt} > DEPTH) begin
                        overflow_d = 1'b1;
                    end
                    state_d = (hdr_cnt == '0) ? AFTER_DATA : DATA;
                end
            end
            DATA: begin
`ifdef IMEM_LOADER_CKSUM_EN
                if (accept) begin
                    xor_d = xor_q ^ in_data;
                end
`endif
                if (word_vld) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                word_cnt_d = next_cnt[CNT_W-1:0];
                state_d    = (next_cnt < {1'b0, count_q}) ? DATA : AFTER_DATA;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            CKSUM: begin
                if (accept) begin
                    cksum_err_d = (in_data != xor_q);
                    state_d     = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_cnt_q <= '0;
            overflow_q <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q       <= '0;
            cksum_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            overflow_q <= overflow_d;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q       <= xor_d;
            cksum_err_q <= cksum_err_d;
`endif
        end
    end

    assign mem_we    = (state_q == WRITE) && in_range;
    assign mem_addr  = word_cnt_q[ADDR_W-1:0];
    assign mem_wdata = word_dat;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign overflow  = overflow_q;
    assign word_cnt  = word_cnt_q;
`ifdef IMEM_LOADER_CKSUM_EN
    assign cksum_err = cksum_err_q;
`else
    assign cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a full-size instance and a 4-word instance (ADDR_W=2) share one
// stimulus driver, selected by sel. Expected writes are queued as bytes are sent and
// popped by a monitor whenever the selected instance strobes mem_we.
module tb_imem_loader;
    import imem_pkg::*;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    bit          sel;

    int n_checks = 0;
    int n_pass   = 0;
    wr_t exp_q[$];
    logic [7:0] model_xor;

    always #5 clk = ~clk;

    // Instance A: full 256-word memory.
    logic        a_in_ready, a_mem_we, a_busy, a_done, a_overflow, a_cksum_err;
    logic [7:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [15:0] a_word_cnt;
    // Instance B: 4-word memory for overflow behaviour.
    logic        b_in_ready, b_mem_we, b_busy, b_done, b_overflow, b_cksum_err;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [15:0] b_word_cnt;

    imem_loader #(.ADDR_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start && !sel),
        .in_valid(in_valid && !sel), .in_data(in_data), .in_ready(a_in_ready),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .busy(a_busy), .done(a_done), .overflow(a_overflow),
        .word_cnt(a_word_cnt), .cksum_err(a_cksum_err)
    );

    imem_loader #(.ADDR_W(2), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel),
        .in_valid(in_valid && sel), .in_data(in_data), .in_ready(b_in_ready),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .busy(b_busy), .done(b_done), .overflow(b_overflow),
        .word_cnt(b_word_cnt), .cksum_err(b_cksum_err)
    );

    logic        o_in_ready, o_mem_we, o_busy, o_done, o_overflow, o_cksum_err;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [15:0] o_word_cnt;

    assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign o_mem_we    = sel ? b_mem_we    : a_mem_we;
    assign o_mem_addr  = sel ? {6'd0, b_mem_addr} : a_mem_addr;
    assign o_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
    assign o_busy      = sel ? b_busy      : a_busy;
    assign o_done      = sel ? b_done      : a_done;
    assign o_overflow  = sel ? b_overflow  : a_overflow;
    assign o_word_cnt  = sel ? b_word_cnt  : a_word_cnt;
    assign o_cksum_err = sel ? b_cksum_err : a_cksum_err;

    // Scoreboard monitor: every write strobe must match the oldest queued write,
    // and the loader must not accept bytes in that cycle.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst_n === 1'b1 && o_mem_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write addr=%h data=%h, required no write", o_mem_addr, o_mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (o_mem_addr !== e.addr || o_mem_wdata !== e.data)
                    $display("FAIL write addr=%h data=%h, required addr=%h data=%h",
                             o_mem_addr, o_mem_wdata, e.addr, e.data);
                else
                    n_pass++;
            end
            n_checks++;
            if (o_in_ready !== 1'b0) $display("FAIL ready_in_write got %b, required 0", o_in_ready);
            else n_pass++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // All drivers run from posedge+1 and return at posedge+1.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_xor = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int t = 0;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                start    = 1'($urandom_range(0, 1));   // must be ignored while busy
                @(posedge clk); #1;
            end
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (o_in_ready === 1'b1) begin
                @(posedge clk); #1;
                break;
            end
            t++;
            if (t > 50) begin
                n_checks++;
                $display("FAIL byte_timeout in_ready stuck at %b, required 1", o_in_ready);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input bit in_range, input bit rnd);
        wr_t e;
        if (in_range) begin
            e.addr = 8'(idx);
            e.data = w;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            model_xor = model_xor ^ w[8*i +: 8];
            send_byte(w[8*i +: 8], rnd);
        end
        @(negedge clk);
        n_checks++;
        if (o_mem_we !== in_range) $display("FAIL we_timing word %0d mem_we=%b, required %b", idx, o_mem_we, in_range);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    // Trailing checksum byte when the feature is built in; nothing otherwise.
    task automatic send_tail(input logic [7:0] cks, input bit rnd);
`ifdef IMEM_LOADER_CKSUM_EN
        send_byte(cks, rnd);
`else
        if (rnd && cks == 8'hFF) @(posedge clk);
`endif
    endtask

    task automatic check_end(input string name, input logic [15:0] cnt, input logic ovf, input logic cerr);
        @(negedge clk);
        n_checks++;
        if ({o_done, o_busy, o_overflow, o_cksum_err} !== {1'b1, 1'b0, ovf, cerr})
            $display("FAIL %s_flags done/busy/ovf/cerr=%b, required %b", name,
                     {o_done, o_busy, o_overflow, o_cksum_err}, {1'b1, 1'b0, ovf, cerr});
        else n_pass++;
        n_checks++;
        if (o_word_cnt !== cnt) $display("FAIL %s_word_cnt got %0d, required %0d", name, o_word_cnt, cnt);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s_missing_writes got %0d pending, required 0", name, exp_q.size());
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if ({o_in_ready, o_mem_we, o_busy, o_done, o_overflow, o_cksum_err} !== 6'b0)
            $display("FAIL %s_flags got %b, required 000000", name,
                     {o_in_ready, o_mem_we, o_busy, o_done, o_overflow, o_cksum_err});
        else n_pass++;
        n_checks++;
        if (o_word_cnt !== 16'd0 || o_mem_addr !== 8'd0)
            $display("FAIL %s_cnt_addr got %0d/%h, required 0/00", name, o_word_cnt, o_mem_addr);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_zero("reset");
        n_checks++;
        if (o_mem_wdata !== 32'd0) $display("FAIL reset_wdata got %h, required 0", o_mem_wdata);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input bit rnd);
        pulse_start();
        send_byte(8'h02, rnd);
        send_byte(8'h00, rnd);
        send_word(32'h12345678, 0, 1'b1, rnd);
        send_word(32'hDEADBEEF, 1, 1'b1, rnd);
        send_tail(model_xor, rnd);
        check_end(rnd ? "random_valid" : "basic", 16'd2, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_tail(8'h00, 1'b0);
        check_end("empty", 16'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'h44332211, 0, 1'b1, 1'b0);
        send_byte(8'h55, 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'hCAFEF00D, 0, 1'b1, 1'b0);
        send_tail(model_xor, 1'b0);
        check_end("reload", 16'd1, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        pulse_start();
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        n_checks++;
        if (o_overflow !== 1'b1) $display("FAIL ovf_on_hdr got %b, required 1", o_overflow);
        else n_pass++;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++)
            send_word(32'hA0000000 + 32'(i), i % 4, i < 4, 1'b0);
        send_tail(model_xor, 1'b0);
        check_end("overflow", 16'd5, 1'b1, 1'b0);
        // A new start clears the sticky flags and the count.
        pulse_start();
        @(negedge clk);
        n_checks++;
        if ({o_done, o_overflow, o_busy} !== 3'b001 || o_word_cnt !== 16'd0)
            $display("FAIL restart_clear done/ovf/busy=%b cnt=%0d, required 001 cnt=0",
                     {o_done, o_overflow, o_busy}, o_word_cnt);
        else n_pass++;
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

`ifdef IMEM_LOADER_CKSUM_EN
    task automatic test_cksum();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'h12345678, 0, 1'b1, 1'b0);
        send_word(32'hDEADBEEF, 1, 1'b1, 1'b0);
        send_byte(model_xor ^ 8'h5A, 1'b0);
        check_end("cksum_bad", 16'd2, 1'b0, 1'b1);
        pulse_start();
        @(negedge clk);
        n_checks++;
        if (o_cksum_err !== 1'b0) $display("FAIL cksum_clear got %b, required 0", o_cksum_err);
        else n_pass++;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        model_xor = 8'h00;
        test_reset();
        test_basic(1'b0);
        test_empty();
        test_basic(1'b1);
        test_reset_mid_load();
        test_overflow();
`ifdef IMEM_LOADER_CKSUM_EN
        test_cksum();
`endif
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
